// File: rtl/callback_timer_if.sv
// Bundles the per-channel control strobes and status flags of callback_timer.
// The master side (a CPU block or testbench) drives the strobes. The slave side
// (the timer) drives the status outputs back.
`timescale 1ns/1ps

interface callback_timer_if #(
    parameter int ISIZE    = 16,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*ISIZE-1:0] countdown;
    logic [CHANNELS-1:0]       periodic;
    logic [CHANNELS-1:0]       cancel;
    logic [CHANNELS-1:0]       ack;
    logic [CHANNELS-1:0]       callback;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       pending;
    logic                      any_callback;

    modport master (
        output load, countdown, periodic, cancel, ack,
        input  callback, busy, pending, any_callback
    );

    modport slave (
        input  load, countdown, periodic, cancel, ack,
        output callback, busy, pending, any_callback
    );
endinterface

// File: rtl/callback_timer.sv
// Multi-channel callback timer.
// Each channel counts down a loaded delay and then raises a PULSE-cycle
// callback. It then either stops (one-shot) or reloads and repeats (periodic).
// Channels are fully independent. Cancel beats load, and load beats the
// normal countdown.
`timescale 1ns/1ps

module callback_timer #(
    parameter int ISIZE    = 16,
    parameter int CHANNELS = 4,
    parameter int PULSE    = 2
) (
    input  logic           clk,
    input  logic           reset,
    callback_timer_if.slave bus
);
    // The pulse counter only has to hold PULSE-1, and it needs at least one bit.
    localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    logic [CHANNELS-1:0] callback_vec;
    logic [CHANNELS-1:0] busy_vec;
    logic [CHANNELS-1:0] pending_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        state_t           state_q, state_d;
        logic [ISIZE-1:0] count_q, count_d;
        logic [ISIZE-1:0] reload_q, reload_d;
        logic             mode_q, mode_d;
        logic [PW-1:0]    pulse_q, pulse_d;
        logic             fire_enter;
        logic             callback_r, busy_r, pending_r;

        // Next-state logic: cancel first, then load (retrigger), then countdown/fire progression
        always_comb begin
            state_d    = state_q;
            count_d    = count_q;
            reload_d   = reload_q;
            mode_d     = mode_q;
            pulse_d    = pulse_q;
            fire_enter = 1'b0;
            if (bus.cancel[i]) begin
                state_d = IDLE;
            end else if (bus.load[i]) begin
                state_d  = COUNT;
                count_d  = bus.countdown[i*ISIZE +: ISIZE];
                reload_d = bus.countdown[i*ISIZE +: ISIZE];
                mode_d   = bus.periodic[i];
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    COUNT: begin
                        if (count_q != '0) begin
                            count_d = count_q - ISIZE'(1);
                        end else begin
                            state_d    = FIRE;
                            pulse_d    = PW'(PULSE - 1);
                            fire_enter = 1'b1;
                        end
                    end
                    FIRE: begin
                        if (pulse_q != '0) begin
                            pulse_d = pulse_q - PW'(1);
                        end else if (mode_q) begin
                            state_d = COUNT;
                            count_d = reload_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        // State and output registers. The outputs are taken from the next state so they stay glitch-free flops.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q    <= IDLE;
                count_q    <= '0;
                reload_q   <= '0;
                mode_q     <= 1'b0;
                pulse_q    <= '0;
                callback_r <= 1'b0;
                busy_r     <= 1'b0;
                pending_r  <= 1'b0;
            end else begin
                state_q    <= state_d;
                count_q    <= count_d;
                reload_q   <= reload_d;
                mode_q     <= mode_d;
                pulse_q    <= pulse_d;
                callback_r <= (state_d == FIRE);
                busy_r     <= (state_d != IDLE);
                if (fire_enter) begin
                    pending_r <= 1'b1;
                end else if (bus.ack[i]) begin
                    pending_r <= 1'b0;
                end
            end
        end

        assign callback_vec[i] = callback_r;
        assign busy_vec[i]     = busy_r;
        assign pending_vec[i]  = pending_r;
    end

    assign bus.callback     = callback_vec;
    assign bus.busy         = busy_vec;
    assign bus.pending      = pending_vec;
    assign bus.any_callback = |callback_vec;
endmodule

// File: tb/tb_callback_timer.sv
// Directed testbench for callback_timer (ISIZE=16, CHANNELS=4, PULSE=2).
// Inputs change 1ns after each rising edge, and outputs are sampled at the same point.
`timescale 1ns/1ps

module tb_callback_timer;
    localparam int ISIZE    = 16;
    localparam int CHANNELS = 4;
    localparam int PULSE    = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    callback_timer_if #(.ISIZE(ISIZE), .CHANNELS(CHANNELS)) bus();

    callback_timer #(.ISIZE(ISIZE), .CHANNELS(CHANNELS), .PULSE(PULSE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1ns after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load the channels in mask with delay n and mode per; the load is sampled on the next edge.
    // Afterwards, junk is driven on countdown/periodic to show they are ignored without load.
    task automatic applyStimulus(input logic [3:0] mask, input logic [15:0] n, input logic per);
        for (int c = 0; c < CHANNELS; c++) begin
            if (mask[c]) begin
                bus.countdown[c*ISIZE +: ISIZE] = n;
                bus.periodic[c] = per;
            end
        end
        bus.load = mask;
        step(1);
        bus.load      = '0;
        bus.countdown = '1;
        bus.periodic  = '1;
    endtask

    // One-cycle ack strobe
    task automatic pulseAck(input logic [3:0] mask);
        bus.ack = mask;
        step(1);
        bus.ack = '0;
    endtask

    // Main stimulus sequence
    initial begin
        bus.load      = '0;
        bus.countdown = '0;
        bus.periodic  = '0;
        bus.cancel    = '0;
        bus.ack       = '0;
        reset         = 1'b1;
        step(2);
        checkOutput("reset_callback", 32'(bus.callback), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_pending", 32'(bus.pending), 32'h0);
        checkOutput("reset_any", 32'(bus.any_callback), 32'h0);
        reset = 1'b0;
        step(3);
        checkOutput("idle_after_reset", 32'(bus.busy), 32'h0);

        // One-shot, N=3: callback after E+4 and E+5, low after E+6
        $display("[TB] one-shot N=3");
        applyStimulus(4'b0001, 16'd3, 1'b0);
        checkOutput("os_busy_E", 32'(bus.busy), 32'h1);
        step(3);
        checkOutput("os_cb_E3", 32'(bus.callback), 32'h0);
        step(1);
        checkOutput("os_cb_E4", 32'(bus.callback), 32'h1);
        checkOutput("os_pend_E4", 32'(bus.pending), 32'h1);
        step(1);
        checkOutput("os_cb_E5", 32'(bus.callback), 32'h1);
        step(1);
        checkOutput("os_cb_E6", 32'(bus.callback), 32'h0);
        checkOutput("os_busy_E6", 32'(bus.busy), 32'h0);
        checkOutput("os_pend_E6", 32'(bus.pending), 32'h1);
        pulseAck(4'b0001);
        checkOutput("os_pend_ack", 32'(bus.pending), 32'h0);

        // Periodic, N=0: period 3, high for 2 of every 3 cycles
        $display("[TB] periodic N=0");
        applyStimulus(4'b0001, 16'd0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            checkOutput($sformatf("per_cb_%0d", k), 32'(bus.callback), (k % 3 != 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("per_busy_%0d", k), 32'(bus.busy), 32'h1);
        end
        bus.cancel = 4'b0001;
        step(1);
        bus.cancel = '0;
        checkOutput("per_cancel_cb", 32'(bus.callback), 32'h0);
        checkOutput("per_cancel_busy", 32'(bus.busy), 32'h0);
        checkOutput("per_cancel_pend", 32'(bus.pending), 32'h1);
        pulseAck(4'b0001);

        // Retrigger channel 1: load 10, then reload with 2 five cycles later
        $display("[TB] retrigger");
        applyStimulus(4'b0010, 16'd10, 1'b0);
        step(4);
        applyStimulus(4'b0010, 16'd2, 1'b0);
        step(2);
        checkOutput("rt_cb_E2", 32'(bus.callback), 32'h0);
        step(1);
        checkOutput("rt_cb_E3", 32'(bus.callback), 32'h2);
        step(1);
        checkOutput("rt_cb_E4", 32'(bus.callback), 32'h2);
        for (int k = 0; k < 10; k++) begin
            step(1);
            checkOutput($sformatf("rt_quiet_%0d", k), 32'(bus.callback), 32'h0);
        end
        checkOutput("rt_busy", 32'(bus.busy), 32'h0);
        pulseAck(4'b0010);

        // Channels 0 and 2 loaded together with 5
        $display("[TB] coincident channels");
        applyStimulus(4'b0101, 16'd5, 1'b0);
        step(5);
        checkOutput("co_cb_E5", 32'(bus.callback), 32'h0);
        checkOutput("co_any_E5", 32'(bus.any_callback), 32'h0);
        step(1);
        checkOutput("co_cb_E6", 32'(bus.callback), 32'h5);
        checkOutput("co_any_E6", 32'(bus.any_callback), 32'h1);
        step(1);
        checkOutput("co_any_E7", 32'(bus.any_callback), 32'h1);
        step(1);
        checkOutput("co_any_E8", 32'(bus.any_callback), 32'h0);
        pulseAck(4'b0101);
        checkOutput("co_pend_ack", 32'(bus.pending), 32'h0);

        // Ack coinciding with entry into FIRE: set wins, then the held ack clears it
        $display("[TB] ack vs set");
        applyStimulus(4'b0001, 16'd1, 1'b0);
        step(1);
        bus.ack = 4'b0001;
        step(1);
        checkOutput("as_cb", 32'(bus.callback), 32'h1);
        checkOutput("as_pend_set", 32'(bus.pending), 32'h1);
        step(1);
        bus.ack = '0;
        checkOutput("as_pend_clr", 32'(bus.pending), 32'h0);
        step(1);
        checkOutput("as_busy_end", 32'(bus.busy), 32'h0);

        // Load during FIRE truncates the pulse and restarts the count
        $display("[TB] truncate");
        applyStimulus(4'b0100, 16'd0, 1'b0);
        step(1);
        checkOutput("tr_cb_fire", 32'(bus.callback), 32'h4);
        applyStimulus(4'b0100, 16'd4, 1'b0);
        checkOutput("tr_cb_cut", 32'(bus.callback), 32'h0);
        checkOutput("tr_busy", 32'(bus.busy), 32'h4);
        step(4);
        checkOutput("tr_cb_E4", 32'(bus.callback), 32'h0);
        step(1);
        checkOutput("tr_cb_E5", 32'(bus.callback), 32'h4);
        step(2);
        checkOutput("tr_busy_end", 32'(bus.busy), 32'h0);
        pulseAck(4'b0100);

        // Cancel and load on the same edge: cancel wins
        $display("[TB] cancel priority");
        bus.countdown[1*ISIZE +: ISIZE] = 16'd3;
        bus.cancel = 4'b0010;
        bus.load   = 4'b0010;
        step(1);
        bus.cancel = '0;
        bus.load   = '0;
        checkOutput("cp_busy", 32'(bus.busy), 32'h0);

        // Asynchronous reset in the middle of FIRE
        $display("[TB] async reset during FIRE");
        applyStimulus(4'b1000, 16'd2, 1'b1);
        step(3);
        checkOutput("ar_cb_fire", 32'(bus.callback), 32'h8);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_cb", 32'(bus.callback), 32'h0);
        checkOutput("ar_busy", 32'(bus.busy), 32'h0);
        checkOutput("ar_pend", 32'(bus.pending), 32'h0);
        checkOutput("ar_any", 32'(bus.any_callback), 32'h0);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            checkOutput($sformatf("ar_quiet_%0d", k), 32'({bus.callback, bus.busy, bus.pending}), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
